pb_conditioner: RTL

Input conditioner for the four pushbuttons that feed the processor's `pushbuttons[3:0]` bus, which the IN path drives onto the data bus.

- Synchronises each raw, asynchronous button line into the `clock` domain.
- Debounces each line with a per-bit consecutive-sample counter.
- Presents a stable level vector to the processor.
- Latches per-button press events, which a one-cycle read acknowledge clears, so short presses are not lost between IN instructions.

---
 rtl/pb_conditioner.sv | 68 ++++++
 1 files changed

// File: rtl/pb_conditioner.sv
// Pushbutton input conditioner: two-flop synchroniser, per-bit consecutive-sample
// debounce, and sticky rising-edge press flags cleared by a read acknowledge.
module pb_conditioner #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       rd_ack,
    output logic [3:0] pb_level,
    output logic [3:0] pb_press,
    output logic       pb_event
);

    localparam int unsigned NB = 4;
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [NB-1:0] sync_q1;
    logic [NB-1:0] sync_q2;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic [NB-1:0] level_d;
    logic [NB-1:0] rise;
    logic [NB-1:0] press_d;

    // Debounce counters, next stable level and press-flag update
    always_comb begin
        level_d = pb_level;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync_q2[i] != pb_level[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = sync_q2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        rise    = level_d & ~pb_level;
        // a rise on the acknowledge edge survives the clear
        press_d = rd_ack ? rise : (pb_press | rise);
    end

    // Synchroniser, counters, stable level and press flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            pb_level <= '0;
            pb_press <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q1  <= btn_raw;
            sync_q2  <= sync_q1;
            pb_level <= level_d;
            pb_press <= press_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pb_event = |pb_press;

endmodule
